memory_stage_module: RTL and testbench

MEM stage of the five-stage MIPS pipeline, directly downstream of the execution stage. It latches EX results into an EX/MEM pipeline register, performs the data-memory load/store, and resolves the branch (`PCSrc`, `branch_target`) back to IF. It also drives a MEM/WB pipeline register toward write-back, with stall and flush control from the hazard unit.

---
 rtl/memory_stage_module.sv | 142 ++++++++++++++
 tb/tb_memory_stage_module.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage_module.sv
// MEM stage of a five-stage MIPS pipeline: EX/MEM register, data memory, branch resolve, MEM/WB.
// Optional alignment check is compiled in with `define MEM_ALIGN_CHECK_EN.
module memory_stage_module #(
    parameter int unsigned MEM_WORDS_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        RegWrite_in,
    input  logic        MemtoReg_in,
    input  logic        Branch_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [31:0] add_result,
    input  logic [31:0] alu_result,
    input  logic [31:0] read_data2,
    input  logic [4:0]  write_reg,
    input  logic        zero,
    output logic        PCSrc,
    output logic [31:0] branch_target,
    output logic        wb_RegWrite,
    output logic        wb_MemtoReg,
    output logic [31:0] wb_read_data,
    output logic [31:0] wb_alu_result,
    output logic [4:0]  wb_write_reg,
    output logic [31:0] mem_alu_result,
    output logic [4:0]  mem_write_reg,
    output logic        mem_RegWrite,
    output logic        misalign_err
);
    localparam int unsigned Words = 1 << MEM_WORDS_LOG2;

    logic        ex_reg_write_q, ex_mem_to_reg_q, ex_branch_q, ex_mem_read_q, ex_mem_write_q;
    logic        ex_zero_q;
    logic [31:0] ex_add_q, ex_alu_q, ex_wdata_q;
    logic [4:0]  ex_write_reg_q;

    logic        wb_reg_write_q, wb_mem_to_reg_q;
    logic [31:0] wb_rdata_q, wb_alu_q;
    logic [4:0]  wb_write_reg_q;

    logic [31:0]               mem_q [Words];
    logic [MEM_WORDS_LOG2-1:0] word_idx;
    logic                      access_ok;
    logic [31:0]               read_data;
    logic                      unused_addr;

    // Flush clears only the control bits; data fields still load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_reg_write_q  <= 1'b0;
            ex_mem_to_reg_q <= 1'b0;
            ex_branch_q     <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            ex_mem_write_q  <= 1'b0;
            ex_zero_q       <= 1'b0;
            ex_add_q        <= '0;
            ex_alu_q        <= '0;
            ex_wdata_q      <= '0;
            ex_write_reg_q  <= '0;
        end else if (flush || !stall) begin
            ex_reg_write_q  <= RegWrite_in & ~flush;
            ex_mem_to_reg_q <= MemtoReg_in & ~flush;
            ex_branch_q     <= Branch_in & ~flush;
            ex_mem_read_q   <= MemRead_in & ~flush;
            ex_mem_write_q  <= MemWrite_in & ~flush;
            ex_zero_q       <= zero;
            ex_add_q        <= add_result;
            ex_alu_q        <= alu_result;
            ex_wdata_q      <= read_data2;
            ex_write_reg_q  <= write_reg;
        end
    end

    assign word_idx    = ex_alu_q[MEM_WORDS_LOG2+1:2];
    assign unused_addr = ^{ex_alu_q[31:MEM_WORDS_LOG2+2], ex_alu_q[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
    logic misaligned;
    logic misalign_q;

    assign misaligned = (ex_mem_read_q | ex_mem_write_q) & (ex_alu_q[1:0] != 2'b00);
    assign access_ok  = ~misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_q | misaligned;
        end
    end

    assign misalign_err = misalign_q;
`else
    assign access_ok    = 1'b1;
    assign misalign_err = 1'b0;
`endif

    // A held store writes only on the edge that releases it.
    always_ff @(posedge clk) begin
        if (ex_mem_write_q && !stall && access_ok) begin
            mem_q[word_idx] <= ex_wdata_q;
        end
    end

    assign read_data = (ex_mem_read_q && access_ok) ? mem_q[word_idx] : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_reg_write_q  <= 1'b0;
            wb_mem_to_reg_q <= 1'b0;
            wb_rdata_q      <= '0;
            wb_alu_q        <= '0;
            wb_write_reg_q  <= '0;
        end else if (stall) begin
            wb_reg_write_q  <= 1'b0;
            wb_mem_to_reg_q <= 1'b0;
            wb_rdata_q      <= '0;
            wb_alu_q        <= '0;
            wb_write_reg_q  <= '0;
        end else begin
            wb_reg_write_q  <= ex_reg_write_q;
            wb_mem_to_reg_q <= ex_mem_to_reg_q;
            wb_rdata_q      <= read_data;
            wb_alu_q        <= ex_alu_q;
            wb_write_reg_q  <= ex_write_reg_q;
        end
    end

    assign PCSrc          = ex_branch_q & ex_zero_q;
    assign branch_target  = ex_add_q;
    assign mem_alu_result = ex_alu_q;
    assign mem_write_reg  = ex_write_reg_q;
    assign mem_RegWrite   = ex_reg_write_q;
    assign wb_RegWrite    = wb_reg_write_q;
    assign wb_MemtoReg    = wb_mem_to_reg_q;
    assign wb_read_data   = wb_rdata_q;
    assign wb_alu_result  = wb_alu_q;
    assign wb_write_reg   = wb_write_reg_q;

endmodule

// File: tb/tb_memory_stage_module.sv
// Bench for memory_stage_module: vector table with a MEM/WB scoreboard plus stall/flush/reset
// sequences; the misalignment sequence runs only when MEM_ALIGN_CHECK_EN is defined.
module tb_memory_stage_module;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush;
    logic        RegWrite_in, MemtoReg_in, Branch_in, MemRead_in, MemWrite_in, zero;
    logic [31:0] add_result, alu_result, read_data2;
    logic [4:0]  write_reg;
    logic        PCSrc, wb_RegWrite, wb_MemtoReg, mem_RegWrite, misalign_err;
    logic [31:0] branch_target, wb_read_data, wb_alu_result, mem_alu_result;
    logic [4:0]  wb_write_reg, mem_write_reg;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    memory_stage_module #(.MEM_WORDS_LOG2(8)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .Branch_in(Branch_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .add_result(add_result), .alu_result(alu_result), .read_data2(read_data2),
        .write_reg(write_reg), .zero(zero),
        .PCSrc(PCSrc), .branch_target(branch_target),
        .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg), .wb_read_data(wb_read_data),
        .wb_alu_result(wb_alu_result), .wb_write_reg(wb_write_reg),
        .mem_alu_result(mem_alu_result), .mem_write_reg(mem_write_reg),
        .mem_RegWrite(mem_RegWrite), .misalign_err(misalign_err)
    );

    typedef struct {
        logic        rw, m2r, br, mr, mw, z, fl;
        logic [31:0] add, alu, wd;
        logic [4:0]  wr;
        logic        e_pc, e_rw;
        logic [31:0] e_rd;
    } vec_t;

    typedef struct {
        logic        rw, m2r;
        logic [31:0] rd, alu;
        logic [4:0]  wr;
    } wb_exp_t;

    vec_t    vecs[14];
    wb_exp_t sb[$];

    function automatic vec_t mk(input logic rw, m2r, br, mr, mw, z, fl,
                                input logic [31:0] add, alu, wd, input logic [4:0] wr,
                                input logic e_pc, e_rw, input logic [31:0] e_rd);
        vec_t v;
        v.rw = rw; v.m2r = m2r; v.br = br; v.mr = mr; v.mw = mw; v.z = z; v.fl = fl;
        v.add = add; v.alu = alu; v.wd = wd; v.wr = wr;
        v.e_pc = e_pc; v.e_rw = e_rw; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rw, m2r, br, mr, mw, z, input logic [31:0] add, alu, wd,
                         input logic [4:0] wr, input logic st, fl);
        RegWrite_in = rw; MemtoReg_in = m2r; Branch_in = br; MemRead_in = mr;
        MemWrite_in = mw; zero = z; add_result = add; alu_result = alu; read_data2 = wd;
        write_reg = wr; stall = st; flush = fl;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check();
        wb_exp_t e;
        e = sb.pop_front();
        chk("wb_RegWrite", {31'b0, wb_RegWrite}, {31'b0, e.rw});
        chk("wb_MemtoReg", {31'b0, wb_MemtoReg}, {31'b0, e.m2r});
        chk("wb_read_data", wb_read_data, e.rd);
        chk("wb_alu_result", wb_alu_result, e.alu);
        chk("wb_write_reg", {27'b0, wb_write_reg}, {27'b0, e.wr});
    endtask

    initial begin
        wb_exp_t e;
        //           rw m2r br mr mw z fl  add       alu       wd            wr   pc rw rd
        vecs[0]  = mk(0, 0, 0, 0, 1, 0, 0, 32'h0,  32'h10,   32'hDEADBEEF, 5'd0, 0, 0, 32'h0);
        vecs[1]  = mk(1, 1, 0, 1, 0, 0, 0, 32'h0,  32'h10,   32'h0,       5'd5,  0, 1, 32'hDEADBEEF);
        vecs[2]  = mk(0, 0, 1, 0, 0, 1, 0, 32'h40, 32'h0,    32'h0,       5'd0,  1, 0, 32'h0);
        vecs[3]  = mk(0, 0, 1, 0, 0, 1, 1, 32'h40, 32'h0,    32'h0,       5'd0,  0, 0, 32'h0);
        vecs[4]  = mk(0, 0, 1, 0, 0, 0, 0, 32'h80, 32'h0,    32'h0,       5'd0,  0, 0, 32'h0);
        vecs[5]  = mk(1, 0, 0, 0, 0, 1, 0, 32'h0,  32'h1234, 32'h99,      5'd7,  0, 1, 32'h0);
        vecs[6]  = mk(0, 0, 0, 0, 1, 0, 0, 32'h0,  32'h400,  32'hCAFEF00D, 5'd0, 0, 0, 32'h0);
        vecs[7]  = mk(1, 1, 0, 1, 0, 0, 0, 32'h0,  32'h0,    32'h0,       5'd8,  0, 1, 32'hCAFEF00D);
        vecs[8]  = mk(1, 1, 0, 1, 0, 0, 1, 32'h0,  32'h400,  32'h0,       5'd9,  0, 0, 32'h0);
        vecs[9]  = mk(1, 1, 0, 1, 0, 0, 0, 32'h0,  32'h10,   32'h0,       5'd10, 0, 1, 32'hDEADBEEF);
        vecs[10] = mk(0, 0, 0, 0, 1, 0, 1, 32'h0,  32'h10,   32'h11111111, 5'd0, 0, 0, 32'h0);
        vecs[11] = mk(1, 1, 0, 1, 0, 0, 0, 32'h0,  32'h10,   32'h0,       5'd11, 0, 1, 32'hDEADBEEF);
        vecs[12] = mk(0, 0, 0, 0, 1, 0, 0, 32'h0,  32'h7FC,  32'hA5A5A5A5, 5'd0, 0, 0, 32'h0);
        vecs[13] = mk(1, 1, 0, 1, 0, 0, 0, 32'h0,  32'h3FC,  32'h0,       5'd12, 0, 1, 32'hA5A5A5A5);

        // Reset with busy inputs: everything must read zero.
        rst_n = 1'b0;
        drive(1, 1, 1, 1, 1, 1, 32'h44, 32'h18, 32'h77, 5'd3, 0, 0);
        tick();
        chk("reset PCSrc", {31'b0, PCSrc}, 32'h0);
        chk("reset branch_target", branch_target, 32'h0);
        chk("reset wb_RegWrite", {31'b0, wb_RegWrite}, 32'h0);
        chk("reset wb_read_data", wb_read_data, 32'h0);
        chk("reset wb_alu_result", wb_alu_result, 32'h0);
        chk("reset mem_alu_result", mem_alu_result, 32'h0);
        chk("reset misalign_err", {31'b0, misalign_err}, 32'h0);
        nop();
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].rw, vecs[i].m2r, vecs[i].br, vecs[i].mr, vecs[i].mw, vecs[i].z,
                  vecs[i].add, vecs[i].alu, vecs[i].wd, vecs[i].wr, 0, vecs[i].fl);
            e.rw = vecs[i].e_rw; e.m2r = vecs[i].m2r & ~vecs[i].fl; e.rd = vecs[i].e_rd;
            e.alu = vecs[i].alu; e.wr = vecs[i].wr;
            sb.push_back(e);
            tick();
            chk($sformatf("vec%0d PCSrc", i), {31'b0, PCSrc}, {31'b0, vecs[i].e_pc});
            chk($sformatf("vec%0d branch_target", i), branch_target, vecs[i].add);
            chk($sformatf("vec%0d mem_alu_result", i), mem_alu_result, vecs[i].alu);
            chk($sformatf("vec%0d mem_write_reg", i), {27'b0, mem_write_reg},
                {27'b0, vecs[i].wr});
            chk($sformatf("vec%0d mem_RegWrite", i), {31'b0, mem_RegWrite},
                {31'b0, vecs[i].rw & ~vecs[i].fl});
            if (sb.size() > 1) pop_check();
        end
        nop();
        tick();
        while (sb.size() > 0) pop_check();

        // Store held by a 3-cycle stall: bubbles into MEM/WB, single write on release.
        drive(0, 0, 0, 0, 1, 0, 32'h0, 32'h20, 32'h5555AAAA, 5'd0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 1, 0, 32'h0, 32'h20, 32'h11111111, 5'd3, 1, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("stall%0d wb_RegWrite", k), {31'b0, wb_RegWrite}, 32'h0);
            chk($sformatf("stall%0d wb_alu_result", k), wb_alu_result, 32'h0);
            chk($sformatf("stall%0d mem_RegWrite", k), {31'b0, mem_RegWrite}, 32'h0);
        end
        drive(1, 1, 0, 1, 0, 0, 32'h0, 32'h20, 32'h0, 5'd9, 0, 0);
        tick();
        nop();
        tick();
        chk("stall load wb_read_data", wb_read_data, 32'h5555AAAA);
        chk("stall load wb_RegWrite", {31'b0, wb_RegWrite}, 32'h1);

        // Stall and flush together: the pending store is dropped, MEM/WB bubbles.
        drive(0, 0, 0, 0, 1, 0, 32'h0, 32'h24, 32'h0BADF00D, 5'd0, 0, 0);
        tick();
        nop();
        tick();
        drive(0, 0, 0, 0, 1, 0, 32'h0, 32'h24, 32'h600DCAFE, 5'd0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd4, 1, 1);
        tick();
        chk("stall+flush wb_RegWrite", {31'b0, wb_RegWrite}, 32'h0);
        chk("stall+flush mem_RegWrite", {31'b0, mem_RegWrite}, 32'h0);
        drive(1, 1, 0, 1, 0, 0, 32'h0, 32'h24, 32'h0, 5'd6, 0, 0);
        tick();
        nop();
        tick();
        chk("stall+flush load", wb_read_data, 32'h0BADF00D);

        // Reset asserted while a store sits in EX/MEM cancels the write.
        drive(0, 0, 0, 0, 1, 0, 32'h0, 32'h28, 32'h12345678, 5'd0, 0, 0);
        tick();
        nop();
        tick();
        drive(0, 0, 0, 0, 1, 0, 32'h0, 32'h28, 32'h87654321, 5'd0, 0, 0);
        tick();
        rst_n = 1'b0;
        nop();
        #1;
        chk("mid-store reset mem_alu_result", mem_alu_result, 32'h0);
        tick();
        rst_n = 1'b1;
        drive(1, 1, 0, 1, 0, 0, 32'h0, 32'h28, 32'h0, 5'd2, 0, 0);
        tick();
        nop();
        tick();
        chk("mid-store reset load", wb_read_data, 32'h12345678);

`ifdef MEM_ALIGN_CHECK_EN
        drive(0, 0, 0, 0, 1, 0, 32'h0, 32'h13, 32'hFFFF0000, 5'd0, 0, 0);
        tick();
        nop();
        tick();
        chk("misalign_err set", {31'b0, misalign_err}, 32'h1);
        drive(1, 1, 0, 1, 0, 0, 32'h0, 32'h10, 32'h0, 5'd1, 0, 0);
        tick();
        nop();
        tick();
        chk("misaligned store suppressed", wb_read_data, 32'hDEADBEEF);
        tick();
        chk("misalign_err sticky", {31'b0, misalign_err}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("misalign_err cleared", {31'b0, misalign_err}, 32'h0);
        rst_n = 1'b1;
`else
        chk("misalign_err tied low", {31'b0, misalign_err}, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
